lc_sweep_checker: RTL
=====================

Name: lc_sweep_checker

Overview:
Self-checking exhaustive truth-table sweeper for small combinational logic circuits. Drives every combination of an N_IN-bit input vector into a circuit under test. After a programmable settle time, compares the circuit's N_OUT-bit response against a reference model's response and reports a mismatch count, the first failing vector and pass/fail. Sits beside any combinational logic block as an on-chip replacement for hand-written per-vector testbenches.

Parameters:
N_IN, 3, stimulus width; sweep covers 2**N_IN vectors (1..16 supported)
N_OUT, 5, width of compared response
SETTLE, 2, clock cycles each vector is held before compare (>=1)
GRAY, 0, 0 = binary order sweep, 1 = Gray-code order sweep

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a sweep
dut_out  in  N_OUT  response of circuit under test to stim
ref_out  in  N_OUT  response of reference model to stim
cmp_mask  in  N_OUT  1 = bit participates in compare; sampled with each compare
stim  out  N_IN  registered stimulus vector
busy  out  1  high while sweep in progress
done  out  1  high from sweep end until next accepted start
pass  out  1  valid when done; 1 iff err_count==0
err_count  out  N_IN+1  number of mismatching vectors in last sweep
first_fail  out  N_IN  stim value of first mismatching vector
first_fail_vld  out  1  first_fail holds a captured value

Behaviour:
- Reset (async, rst_n low): state IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_vld=0, internal index and settle counter 0. Reset mid-sweep aborts immediately; no partial results retained.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: clear err_count, first_fail, first_fail_vld, done, pass; idx=0, settle cnt=0; stim=enc(0); busy=1; go RUN. start in RUN ignored.
- enc(i) = i when GRAY=0; i ^ (i>>1) when GRAY=1.
- RUN: each vector held exactly SETTLE cycles. cnt counts 0..SETTLE-1. In cycle with cnt==SETTLE-1: mismatch = |((dut_out ^ ref_out) & cmp_mask); if mismatch, err_count+=1, and if first_fail_vld==0 then first_fail=stim, first_fail_vld=1.
  - Same cycle: if idx==2**N_IN-1 -> DONE next cycle (busy=0, done=1, pass=(final err_count==0), stim holds last vector); else idx+=1, stim=enc(idx+1), cnt=0.
- Sweep length: exactly 2**N_IN * SETTLE cycles of busy=1; done rises the cycle after the last compare.
- err_count max 2**N_IN, fits in N_IN+1 bits; no saturation needed.
- cmp_mask all-zero -> every vector passes.
- DONE holds all results until next start; start in DONE restarts (results cleared in the accepting cycle).
- idx is N_IN+1 bits wide internally to avoid wrap at the terminal check.

Decomposition:
- Package lc_sweep_pkg: state enum (IDLE, RUN, DONE), constants ORDER_BINARY=0 and ORDER_GRAY=1.
- Sub-module lc_vec_gen: index counter plus binary/Gray encoder producing stim and a last-vector flag. Parameters N_IN, GRAY. Inputs clk, rst_n, clr, adv.

Test Plan:
- N_IN=3, SETTLE=2, GRAY=0; dut_out tied to ref_out; mask=5'h1F; pulse start -> stim 0..7, each held 2 cycles; busy high 16 cycles; done=1, pass=1, err_count=0, first_fail_vld=0.
- Same config; dut_out bit0 inverted when stim==3'b101 -> err_count=1, first_fail=3'b101, first_fail_vld=1, pass=0.
- Same fault but cmp_mask=5'h1E -> err_count=0, pass=1.
- GRAY=1 -> stim sequence 000,001,011,010,110,111,101,100; dut_out inverted on all vectors -> err_count=8 (4'b1000), first_fail=000.
- Start pulsed again mid-run at cycle 5 -> ignored; total busy still 16 cycles. rst_n low at cycle 9 -> all outputs 0 asynchronously, state IDLE. After release, new start runs the full sweep.
- Restart from DONE after a failing sweep with the fault removed -> err_count, first_fail_vld and pass cleared on the accept cycle; final pass=1.

Source files
------------

// File: rtl/lc_sweep_pkg.sv
// ---------------------------------------------------------------------------
// lc_sweep_pkg
// Shared types and constants for the exhaustive truth-table sweeper.
//   sweep_state_e : controller state (idle, sweeping, results held)
//   ORDER_BINARY  : sweep vectors in plain binary order
//   ORDER_GRAY    : sweep vectors in reflected Gray-code order
// ---------------------------------------------------------------------------
package lc_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

  localparam int ORDER_BINARY = 0;
  localparam int ORDER_GRAY   = 1;

endpackage : lc_sweep_pkg

// File: rtl/lc_vec_gen.sv
// ---------------------------------------------------------------------------
// lc_vec_gen
// Vector index counter plus binary/Gray encoder. Produces the registered
// stimulus for the current index and flags when the index is the last one
// of the sweep.
//
// Parameters
//   N_IN : stimulus width (sweep covers 2**N_IN vectors)
//   GRAY : ORDER_BINARY or ORDER_GRAY
// Ports
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   clr   in   restart the sweep at index 0 (stim = enc(0))
//   adv   in   step to the next index (ignored while clr is high)
//   stim  out  registered stimulus, enc(index)
//   last  out  current index is 2**N_IN-1
// ---------------------------------------------------------------------------
module lc_vec_gen
  import lc_sweep_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int GRAY = ORDER_BINARY
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            adv,
  output logic [N_IN-1:0] stim,
  output logic            last
);

  // The index is one bit wider than the stimulus so the terminal index
  // 2**N_IN-1 never aliases with a wrapped 0 when it is compared.
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'((1 << N_IN) - 1);
  localparam logic [N_IN:0] IDX_ONE  = (N_IN+1)'(1);
  localparam logic [N_IN:0] IDX_ZERO = (N_IN+1)'(0);

  logic [N_IN:0]   idx_r;
  logic [N_IN:0]   idx_nxt_s;
  logic [N_IN-1:0] stim_r;

  // Map an index onto the stimulus value in the selected sweep order.
  function automatic logic [N_IN-1:0] enc(input logic [N_IN:0] i);
    logic [N_IN-1:0] b;
    b = i[N_IN-1:0];
    if (GRAY == ORDER_GRAY) begin
      enc = b ^ (b >> 1);
    end else begin
      enc = b;
    end
  endfunction

  // Next index, used both for the counter and the look-ahead encode.
  always_comb begin
    idx_nxt_s = idx_r + IDX_ONE;
  end

  // Index counter; stim is encoded from the next index so it is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= IDX_ZERO;
      stim_r <= {N_IN{1'b0}};
    end else if (clr) begin
      idx_r  <= IDX_ZERO;
      stim_r <= enc(IDX_ZERO);
    end else if (adv) begin
      idx_r  <= idx_nxt_s;
      stim_r <= enc(idx_nxt_s);
    end else begin
      idx_r  <= idx_r;
      stim_r <= stim_r;
    end
  end

  assign stim = stim_r;
  assign last = (idx_r == LAST_IDX);

endmodule : lc_vec_gen

// File: rtl/lc_sweep_checker.sv
// ---------------------------------------------------------------------------
// lc_sweep_checker
// Exhaustive truth-table sweeper. Applies every N_IN-bit vector to a
// circuit under test, holds each for SETTLE cycles, then compares the
// masked response against a reference model and accumulates results.
//
// Parameters
//   N_IN   : stimulus width (1..16)
//   N_OUT  : compared response width
//   SETTLE : cycles each vector is held (>=1); compare in the last one
//   GRAY   : 0 binary order, 1 Gray-code order
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset (aborts any sweep)
//   start          in   one-cycle sweep request, accepted in IDLE/DONE
//   dut_out        in   response of the circuit under test
//   ref_out        in   response of the reference model
//   cmp_mask       in   per-bit compare enable, sampled at each compare
//   stim           out  registered stimulus vector
//   busy           out  sweep in progress
//   done           out  sweep finished, results valid
//   pass           out  no mismatching vector in the last sweep
//   err_count      out  number of mismatching vectors
//   first_fail     out  stimulus of the first mismatching vector
//   first_fail_vld out  first_fail holds a captured value
// ---------------------------------------------------------------------------
module lc_sweep_checker
  import lc_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 5,
  parameter int SETTLE = 2,
  parameter int GRAY   = ORDER_BINARY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_OUT-1:0] dut_out,
  input  logic [N_OUT-1:0] ref_out,
  input  logic [N_OUT-1:0] cmp_mask,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_fail,
  output logic             first_fail_vld
);

  // A one-cycle settle still needs a 1-bit counter to keep widths legal.
  localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN:0]    ERR_ONE  = (N_IN+1)'(1);
  localparam logic [N_IN:0]    ERR_ZERO = (N_IN+1)'(0);

  sweep_state_e     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [N_IN:0]    err_count_r;
  logic [N_IN-1:0]  first_fail_r;
  logic             first_fail_vld_r;

  logic             compare_s;
  logic             mismatch_s;
  logic [N_IN:0]    err_nxt_s;
  logic             clr_s;
  logic             adv_s;
  logic             last_s;
  logic [N_IN-1:0]  stim_s;

  // Any differing bit that is enabled by the mask counts as a failure.
  function automatic logic vec_mismatch(
    input logic [N_OUT-1:0] a,
    input logic [N_OUT-1:0] b,
    input logic [N_OUT-1:0] m
  );
    vec_mismatch = |((a ^ b) & m);
  endfunction

  lc_vec_gen #(
    .N_IN (N_IN),
    .GRAY (GRAY)
  ) u_vec_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .adv   (adv_s),
    .stim  (stim_s),
    .last  (last_s)
  );

  // Compare strobe, mismatch result and vector-generator controls.
  always_comb begin
    compare_s  = 1'b0;
    mismatch_s = 1'b0;
    err_nxt_s  = err_count_r;
    clr_s      = 1'b0;
    adv_s      = 1'b0;
    if (state_r == ST_RUN) begin
      compare_s = (cnt_r == CNT_LAST);
    end else begin
      clr_s = start;
    end
    if (compare_s) begin
      mismatch_s = vec_mismatch(dut_out, ref_out, cmp_mask);
      adv_s      = ~last_s;
    end else begin
      mismatch_s = 1'b0;
      adv_s      = 1'b0;
    end
    if (mismatch_s) begin
      err_nxt_s = err_count_r + ERR_ONE;
    end else begin
      err_nxt_s = err_count_r;
    end
  end

  // Sweep controller: accept, per-vector settle/compare, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      cnt_r            <= {CNT_W{1'b0}};
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      err_count_r      <= ERR_ZERO;
      first_fail_r     <= {N_IN{1'b0}};
      first_fail_vld_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r          <= ST_RUN;
            cnt_r            <= {CNT_W{1'b0}};
            busy_r           <= 1'b1;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            err_count_r      <= ERR_ZERO;
            first_fail_r     <= {N_IN{1'b0}};
            first_fail_vld_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (compare_s) begin
            err_count_r <= err_nxt_s;
            // Only the earliest failing vector is recorded.
            if (mismatch_s && !first_fail_vld_r) begin
              first_fail_r     <= stim_s;
              first_fail_vld_r <= 1'b1;
            end
            if (last_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              // Must include the final vector's outcome, hence err_nxt_s.
              pass_r  <= (err_nxt_s == ERR_ZERO);
            end else begin
              cnt_r <= {CNT_W{1'b0}};
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign stim           = stim_s;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_count_r;
  assign first_fail     = first_fail_r;
  assign first_fail_vld = first_fail_vld_r;

endmodule : lc_sweep_checker
